// File: rtl/bali_stack_pkg.sv
// Shared types and sizing for the byte-stack operation sequencer.
package bali_stack_pkg;

    localparam int unsigned DATA_W            = 32;
    localparam int unsigned DEPTH_W           = 15;
    localparam int unsigned MAX_DEPTH_DEFAULT = 16384;

    typedef enum logic [2:0] {
        OP_PUSH = 3'b000,
        OP_POP  = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_AND  = 3'b100,
        OP_OR   = 3'b101,
        OP_XOR  = 3'b110,
        OP_RSVD = 3'b111
    } op_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_POP1,
        ST_WAIT1,
        ST_POP2,
        ST_WAIT2,
        ST_EXEC,
        ST_PUSH,
        ST_WAITP,
        ST_FIN
    } state_e;

endpackage

// File: rtl/stack_op_seq.sv
// Sequences PUSH/POP/ALU operations onto an external handshaked word stack.
module stack_op_seq
    import bali_stack_pkg::*;
#(
    parameter int unsigned MAX_DEPTH = MAX_DEPTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               op_valid,
    input  logic [2:0]         op,
    input  logic [DATA_W-1:0]  imm,
    output logic               op_ready,
    output logic               result_valid,
    output logic [DATA_W-1:0]  result,
    output logic               err,
    output logic [DEPTH_W-1:0] depth,
    output logic               stk_trigger,
    output logic               stk_push,
    output logic [DATA_W-1:0]  stk_write_value,
    input  logic [DATA_W-1:0]  stk_read_value,
    input  logic               stk_done
);

    state_e              state;
    op_e                 op_q;
    logic [DATA_W-1:0]   opa;
    logic [DATA_W-1:0]   opb;
    logic [DATA_W-1:0]   alu_c;
    op_e                 op_in_c;

    assign op_in_c = op_e'(op);

    // A is the second-from-top word, B the top; wraps modulo 2^32
    always_comb begin
        alu_c = '0;
        case (op_q)
            OP_ADD:  alu_c = opa + opb;
            OP_SUB:  alu_c = opa - opb;
            OP_AND:  alu_c = opa & opb;
            OP_OR:   alu_c = opa | opb;
            OP_XOR:  alu_c = opa ^ opb;
            default: alu_c = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            op_q            <= OP_PUSH;
            opa             <= '0;
            opb             <= '0;
            op_ready        <= 1'b1;
            result_valid    <= 1'b0;
            result          <= '0;
            err             <= 1'b0;
            depth           <= '0;
            stk_trigger     <= 1'b0;
            stk_push        <= 1'b0;
            stk_write_value <= '0;
        end else begin
            result_valid <= 1'b0;
            err          <= 1'b0;
            stk_trigger  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (op_valid && op_ready) begin
                        op_ready <= 1'b0;
                        op_q     <= op_in_c;
                        case (op_in_c)
                            OP_PUSH: begin
                                if (32'(depth) >= MAX_DEPTH) begin
                                    result_valid <= 1'b1;
                                    err          <= 1'b1;
                                    state        <= ST_FIN;
                                end else begin
                                    stk_write_value <= imm;
                                    stk_trigger     <= 1'b1;
                                    stk_push        <= 1'b1;
                                    state           <= ST_PUSH;
                                end
                            end
                            OP_RSVD: begin
                                result_valid <= 1'b1;
                                err          <= 1'b1;
                                state        <= ST_FIN;
                            end
                            default: begin
                                // POP needs one word, ALU ops need two
                                if ((op_in_c == OP_POP) ? (depth == '0)
                                                        : (depth < DEPTH_W'(2))) begin
                                    result_valid <= 1'b1;
                                    err          <= 1'b1;
                                    state        <= ST_FIN;
                                end else begin
                                    stk_trigger <= 1'b1;
                                    stk_push    <= 1'b0;
                                    state       <= ST_POP1;
                                end
                            end
                        endcase
                    end
                end
                ST_POP1:  state <= ST_WAIT1;
                ST_WAIT1: begin
                    if (stk_done) begin
                        opb   <= stk_read_value;
                        depth <= depth - DEPTH_W'(1);
                        if (op_q == OP_POP) begin
                            result       <= stk_read_value;
                            result_valid <= 1'b1;
                            state        <= ST_FIN;
                        end else begin
                            stk_trigger <= 1'b1;
                            stk_push    <= 1'b0;
                            state       <= ST_POP2;
                        end
                    end
                end
                ST_POP2:  state <= ST_WAIT2;
                ST_WAIT2: begin
                    if (stk_done) begin
                        opa   <= stk_read_value;
                        depth <= depth - DEPTH_W'(1);
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    stk_write_value <= alu_c;
                    stk_trigger     <= 1'b1;
                    stk_push        <= 1'b1;
                    state           <= ST_PUSH;
                end
                ST_PUSH:  state <= ST_WAITP;
                ST_WAITP: begin
                    if (stk_done) begin
                        depth        <= depth + DEPTH_W'(1);
                        result       <= stk_write_value;
                        result_valid <= 1'b1;
                        state        <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    op_ready <= 1'b1;
                    state    <= ST_IDLE;
                end
                default:  state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stack_op_seq.sv
// Directed bench for stack_op_seq with a delayed-done word stack model.
module tb_stack_op_seq;
    import bali_stack_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n = 1'b0;

    logic        op_valid = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] imm = 32'h0;
    logic        op_ready, result_valid, err, stk_trigger, stk_push;
    logic [31:0] result, stk_write_value;
    logic [31:0] stk_read_value = 32'h0;
    logic        stk_done = 1'b0;
    logic [14:0] depth;

    logic        op_valid2 = 1'b0;
    logic [2:0]  op2 = 3'b000;
    logic [31:0] imm2 = 32'h0;
    logic        op_ready2, result_valid2, err2, stk_trigger2, stk_push2;
    logic [31:0] result2, stk_write_value2;
    logic [31:0] stk_read_value2 = 32'h0;
    logic        stk_done2 = 1'b0;
    logic [14:0] depth2;

    stack_op_seq dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op(op), .imm(imm),
        .op_ready(op_ready), .result_valid(result_valid), .result(result), .err(err),
        .depth(depth), .stk_trigger(stk_trigger), .stk_push(stk_push),
        .stk_write_value(stk_write_value), .stk_read_value(stk_read_value),
        .stk_done(stk_done)
    );

    stack_op_seq #(.MAX_DEPTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid2), .op(op2), .imm(imm2),
        .op_ready(op_ready2), .result_valid(result_valid2), .result(result2), .err(err2),
        .depth(depth2), .stk_trigger(stk_trigger2), .stk_push(stk_push2),
        .stk_write_value(stk_write_value2), .stk_read_value(stk_read_value2),
        .stk_done(stk_done2)
    );

    // Word stack: done arrives dly negedges after a trigger is seen
    logic [31:0] mem [0:15];
    int  sp = 0, busy = 0, cnt = 0, dly = 2;
    int  trig_cnt = 0, push_trig = 0, pop_trig = 0, overlap = 0;
    logic cur_push = 1'b0;
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy = 0; sp = 0; stk_done = 1'b0;
        end else begin
            stk_done = 1'b0;
            if (busy != 0) begin
                if (stk_trigger) overlap++;
                cnt--;
                if (cnt == 0) begin
                    busy = 0;
                    stk_done = 1'b1;
                    if (cur_push) begin
                        mem[sp[3:0]] = stk_write_value;
                        sp++;
                    end else begin
                        sp--;
                        stk_read_value = mem[sp[3:0]];
                    end
                end
            end else if (stk_trigger) begin
                busy = 1; cnt = dly; cur_push = stk_push; trig_cnt++;
                if (stk_push) push_trig++; else pop_trig++;
            end
        end
    end

    int pend2 = 0, trig2 = 0;
    always @(negedge clk) begin
        stk_done2 = 1'b0;
        if (pend2 != 0) begin
            stk_done2 = 1'b1; pend2 = 0;
        end else if (stk_trigger2) begin
            pend2 = 1; trig2++;
        end
    end

    int rv_cnt = 0;
    always @(negedge clk) if (result_valid) rv_cnt++;

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic run_op(input bit sel, input logic [2:0] o, input logic [31:0] v,
                          output logic [31:0] res, output logic e, output int lat);
        int n;
        res = 32'h0; e = 1'b0; lat = -1;
        n = 0;
        while (!(sel ? op_ready2 : op_ready) && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) begin chk("ready_timeout", 32'd0, 32'd1); return; end
        if (sel) begin op_valid2 = 1'b1; op2 = o; imm2 = v; end
        else     begin op_valid  = 1'b1; op  = o; imm  = v; end
        @(posedge clk); #1;
        op_valid = 1'b0; op_valid2 = 1'b0;
        @(negedge clk);
        n = 0;
        while (!(sel ? result_valid2 : result_valid) && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) begin chk("done_timeout", 32'd0, 32'd1); return; end
        res = sel ? result2 : result;
        e   = sel ? err2 : err;
        lat = n;
    endtask

    logic [31:0] r;
    logic        e;
    int          lat, t0, p0, q0, rv0, n;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_result", result, 32'h0);
        chk("rst_rvalid", 32'(result_valid), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_depth", 32'(depth), 32'h0);
        chk("rst_trig", 32'(stk_trigger), 32'h0);
        chk("rst_wval", stk_write_value, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(op_ready), 32'h1);

        dly = 2;
        run_op(0, OP_PUSH, 32'h5, r, e, lat);
        chk("push5_res", r, 32'h5);
        chk("push5_err", 32'(e), 32'h0);
        run_op(0, OP_PUSH, 32'h3, r, e, lat);
        t0 = trig_cnt; p0 = push_trig;
        run_op(0, OP_ADD, 32'h0, r, e, lat);
        chk("add_res", r, 32'h8);
        chk("add_depth", 32'(depth), 32'h1);
        chk("add_trigs", 32'(trig_cnt - t0), 32'd3);
        chk("add_pushtrig", 32'(push_trig - p0), 32'd1);
        run_op(0, OP_POP, 32'h0, r, e, lat);
        chk("pop8_res", r, 32'h8);
        chk("pop8_depth", 32'(depth), 32'h0);

        run_op(0, OP_PUSH, 32'h3, r, e, lat);
        run_op(0, OP_PUSH, 32'h5, r, e, lat);
        run_op(0, OP_SUB, 32'h0, r, e, lat);
        chk("sub_res", r, 32'hFFFF_FFFE);
        chk("sub_depth", 32'(depth), 32'h1);
        run_op(0, OP_POP, 32'h0, r, e, lat);

        t0 = trig_cnt;
        run_op(0, OP_POP, 32'h0, r, e, lat);
        chk("pop0_err", 32'(e), 32'h1);
        chk("pop0_lat", 32'(lat), 32'h0);
        chk("pop0_trigs", 32'(trig_cnt - t0), 32'h0);
        chk("pop0_depth", 32'(depth), 32'h0);
        run_op(0, OP_ADD, 32'h0, r, e, lat);
        chk("add0_err", 32'(e), 32'h1);
        run_op(0, OP_PUSH, 32'h7, r, e, lat);
        run_op(0, OP_ADD, 32'h0, r, e, lat);
        chk("add1_err", 32'(e), 32'h1);
        chk("add1_depth", 32'(depth), 32'h1);
        run_op(0, OP_RSVD, 32'h0, r, e, lat);
        chk("rsvd_err", 32'(e), 32'h1);
        run_op(0, OP_POP, 32'h0, r, e, lat);
        chk("pop7_res", r, 32'h7);
        chk("pop7_err", 32'(e), 32'h0);

        run_op(0, OP_PUSH, 32'hF0F0_00FF, r, e, lat);
        run_op(0, OP_PUSH, 32'h0FF0_0F0F, r, e, lat);
        run_op(0, OP_AND, 32'h0, r, e, lat);
        chk("and_res", r, 32'h00F0_000F);
        run_op(0, OP_PUSH, 32'hFFFF_0000, r, e, lat);
        run_op(0, OP_XOR, 32'h0, r, e, lat);
        chk("xor_res", r, 32'hFF0F_000F);
        run_op(0, OP_PUSH, 32'h0000_F0F0, r, e, lat);
        run_op(0, OP_OR, 32'h0, r, e, lat);
        chk("or_res", r, 32'hFF0F_F0FF);
        run_op(0, OP_POP, 32'h0, r, e, lat);
        chk("popor_res", r, 32'hFF0F_F0FF);
        chk("popor_depth", 32'(depth), 32'h0);

        dly = 4;
        t0 = trig_cnt; p0 = push_trig;
        run_op(0, OP_PUSH, 32'hDEAD_BEEF, r, e, lat);
        chk("pushdb_trigs", 32'(trig_cnt - t0), 32'd1);
        chk("pushdb_push", 32'(push_trig - p0), 32'd1);
        chk("pushdb_lat", 32'(lat), 32'd5);
        t0 = trig_cnt; q0 = pop_trig;
        run_op(0, OP_POP, 32'h0, r, e, lat);
        chk("popdb_res", r, 32'hDEAD_BEEF);
        chk("popdb_trigs", 32'(trig_cnt - t0), 32'd1);
        chk("popdb_pop", 32'(pop_trig - q0), 32'd1);

        run_op(1, OP_PUSH, 32'h1, r, e, lat);
        run_op(1, OP_PUSH, 32'h2, r, e, lat);
        chk("full_err0", 32'(e), 32'h0);
        chk("full_depth0", 32'(depth2), 32'h2);
        t0 = trig2;
        run_op(1, OP_PUSH, 32'h3, r, e, lat);
        chk("full_err", 32'(e), 32'h1);
        chk("full_depth", 32'(depth2), 32'h2);
        chk("full_trigs", 32'(trig2 - t0), 32'h0);

        // Reset while the second pop is outstanding
        dly = 6;
        run_op(0, OP_PUSH, 32'h11, r, e, lat);
        run_op(0, OP_PUSH, 32'h22, r, e, lat);
        @(negedge clk);
        q0 = pop_trig;
        op_valid = 1'b1; op = OP_ADD;
        @(posedge clk); #1;
        op_valid = 1'b0;
        n = 0;
        while (pop_trig != q0 + 2 && n < 100) begin @(negedge clk); n++; end
        chk("wait2_reached", 32'(pop_trig - q0), 32'd2);
        repeat (2) @(negedge clk);
        rv0 = rv_cnt;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_depth", 32'(depth), 32'h0);
        chk("arst_wval", stk_write_value, 32'h0);
        chk("arst_trig", 32'(stk_trigger), 32'h0);
        chk("arst_push", 32'(stk_push), 32'h0);
        chk("arst_result", result, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("arst_norv", 32'(rv_cnt), 32'(rv0));
        chk("arst_ready", 32'(op_ready), 32'h1);
        chk("no_overlap", 32'(overlap), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
